hazard_unit: RTL
================

# hazard_unit

Pipeline interlock controller for the 5-stage RISC-V core; the counterpart to operand forwarding, handling hazards that forwarding cannot resolve. It detects load-use dependencies between ID and EX and inserts LOAD_USE_BUBBLES bubbles. It also flushes IF/ID on a taken branch resolved in EX and freezes the whole pipeline while data memory signals wait. Sits beside the decode stage and drives the write-enables and flush/bubble controls of PC, IF/ID and ID/EX.

## Interface
- REG_ADDR_W, 5, register index width
- LOAD_USE_BUBBLES, 1, bubbles per load-use hazard; legal range 1..7
- CNT_W, 32, statistics counter width (stats build only)

- clk  in  1  core clock, all state on rising edge
- arst_n  in  1  asynchronous active-low reset
- rs1_id, rs2_id  in  REG_ADDR_W  source registers of instruction in ID
- rs1_used_id, rs2_used_id  in  1  instruction in ID actually reads rs1/rs2
- rd_ex  in  REG_ADDR_W  destination of instruction in EX
- mem_read_ex  in  1  instruction in EX is a load
- branch_taken_ex  in  1  taken branch/jump resolved in EX this cycle
- mem_stall  in  1  data memory not ready this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_bubble  out  1  ID/EX loads zeroed control (bubble)
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB

## Operation
- hazard = mem_read_ex & rd_ex!=0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
- State: FSM {RUN, BUBBLE} plus bubble counter bcnt (3 bits).
- Priority per cycle: mem_stall > branch_taken_ex > hazard/BUBBLE > normal.
- mem_stall=1 (any state): pipe_freeze=1, pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0; FSM and bcnt hold.
- RUN, branch_taken_ex=1: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1; any hazard is ignored (ID instruction discarded); stay RUN.
- RUN, hazard=1: pc_write=0, if_id_write=0, id_ex_bubble=1. If LOAD_USE_BUBBLES>1, go to BUBBLE with bcnt=LOAD_USE_BUBBLES-1; else stay RUN.
- RUN, otherwise: pc_write=1, if_id_write=1, all other outputs 0.
- BUBBLE: pc_write=0, if_id_write=0, id_ex_bubble=1; bcnt decrements; when bcnt==1 in this cycle, go to RUN. The hazard input is not re-evaluated.
- BUBBLE with branch_taken_ex=1 (illegal, EX holds a bubble): flush outputs as in RUN; FSM returns to RUN, bcnt=0.
- Register x0 is never a hazard.

## Timing
- Outputs are combinational from the current inputs and the registered state; zero-cycle latency to the pipeline enables.
- Total stall per load-use = exactly LOAD_USE_BUBBLES non-frozen cycles; frozen cycles extend it, they do not consume it.
- Flush lasts one cycle per branch_taken_ex pulse. When a flush coincides with mem_stall it is deferred, because EX is held and the branch re-asserts.
- Reset (arst_n low, asynchronous): state=RUN, bcnt=0. Outputs are forced to pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1, pipe_freeze=0. Normal RUN behaviour starts on the first clk edge after release.
- Reset mid-BUBBLE abandons the remaining bubbles.

## Configuration
- HAZARD_UNIT_STATS_EN defined: adds outputs stall_cycles and flush_count, both CNT_W bits wide, saturating, cleared by arst_n.
  - stall_cycles increments on every cycle with id_ex_bubble=1 and no flush.
  - flush_count increments on every cycle with if_id_flush=1.
- Undefined: these ports and their counters do not exist; behaviour is otherwise identical.

## Test plan
- Load x5 in EX, ID uses rs1=x5 with rs1_used_id=1, LOAD_USE_BUBBLES=1 -> exactly one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, then RUN.
- Same with LOAD_USE_BUBBLES=3 and mem_stall high for 2 cycles during the BUBBLE state -> 3 bubble cycles plus 2 frozen cycles (pipe_freeze=1, bubble=0), then RUN.
- rd_ex=0 with mem_read_ex=1 matching rs2_id=0 -> no stall. Match on rs2 with rs2_used_id=0 -> no stall.
- branch_taken_ex=1 together with a load-use hazard -> if_id_flush=1, id_ex_bubble=1, pc_write=1, no stall. With HAZARD_UNIT_STATS_EN: flush_count +1, stall_cycles unchanged.
- branch_taken_ex=1 with mem_stall=1 for one cycle, then mem_stall=0 -> first cycle freeze only, flush in the second cycle.
- arst_n asserted in the middle of BUBBLE (LOAD_USE_BUBBLES=4) -> outputs immediately take their reset values; after release, pc_write=1 with no residual bubbles.

Source files
------------

// File: rtl/hazard_unit.sv
// Load-use interlock, branch flush and memory-wait freeze for the 5-stage core.
// Optional saturating statistics counters are enabled with HAZARD_UNIT_STATS_EN.
module hazard_unit #(
  parameter int REG_ADDR_W       = 5,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  rs1_used_id,
  input  logic                  rs2_used_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  mem_read_ex,
  input  logic                  branch_taken_ex,
  input  logic                  mem_stall,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  pipe_freeze
`ifdef HAZARD_UNIT_STATS_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  typedef enum logic {RUN, BUBBLE} state_t;

  localparam logic [2:0] BCNT_INIT = 3'(LOAD_USE_BUBBLES - 1);

  state_t     state_reg, state_next;
  logic [2:0] bcnt_reg, bcnt_next;
  logic       hazard;

  assign hazard = mem_read_ex && (rd_ex != '0) &&
                  ((rs1_used_id && (rs1_id == rd_ex)) ||
                   (rs2_used_id && (rs2_id == rd_ex)));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg <= RUN;
      bcnt_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      bcnt_reg  <= bcnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bcnt_next    = bcnt_reg;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (!arst_n) begin
      // Outputs follow reset immediately, not only after the next edge.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (mem_stall) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (branch_taken_ex) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_next   = RUN;
      bcnt_next    = 3'd0;
    end else if (state_reg == BUBBLE) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      bcnt_next    = bcnt_reg - 3'd1;
      // <=1 also recovers from a corrupted zero count.
      if (bcnt_reg <= 3'd1) begin
        state_next = RUN;
        bcnt_next  = 3'd0;
      end
    end else if (hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if (LOAD_USE_BUBBLES > 1) begin
        state_next = BUBBLE;
        bcnt_next  = BCNT_INIT;
      end
    end
  end

`ifdef HAZARD_UNIT_STATS_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (id_ex_bubble && !if_id_flush && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (if_id_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule
